iecdrv_head_ctrl: RTL
=====================

# iecdrv_head_ctrl

Parametrised head-positioner and track-flush controller for the IEC drive family (1541/1571-class). It decodes the 2-bit stepper phase from the drive logic into a half-track position and publishes a settled track/side to the GCR and track-loader blocks. It also tracks whether the loaded track is dirty and issues save requests to the track loader through a req/ack handshake. Unlike the single-purpose stepping logic it replaces, it adds head settle delay, double-sided support, idle-timeout flushing and explicit save handshaking.

## Interface
- MAX_HTRACK, 80: highest reachable half-track.
- START_HTRACK, 36: half-track loaded at reset.
- SIDES, 1: 1 or 2; with 1, side_i is ignored and side_o is held at 0.
- SETTLE, 0: ce ticks with no step before a new track is published. 0 means publish on the next clk.
- IDLE_FLUSH, 0: ce ticks after the last we before a dirty track flushes. 0 disables this flush.
- HT_W, $clog2(MAX_HTRACK+1): half-track width (derived).
- clk  in  1  drive clock.
- reset  in  1  asynchronous, active-high.
- ce  in  1  drive clock enable.
- stp  in  2  stepper phase.
- mtr  in  1  spindle motor on.
- act  in  1  drive activity (LED).
- side_i  in  1  requested head side.
- we  in  1  GCR write strobe (track data modified).
- img_mounted  in  1  image change level; rising edge is the event.
- htrack  out  HT_W  raw half-track position.
- track_o  out  HT_W-1  settled track number, htrack>>1.
- side_o  out  1  settled side.
- tr00_n  out  1  low when htrack>>1 == 0.
- busy  out  1  settle pending OR save_req.
- save_req  out  1  save request level.
- save_track  out  HT_W-1  track to save, stable while save_req is high.
- save_side  out  1  side to save, stable while save_req is high.
- save_ack  in  1  loader accepted the request.

## Operation
- **Step decode, every clk:**
  - stp_prev <= stp, always.
  - move = stp - stp_prev, mod 4.
  - Steps are accepted only when mtr=1.
  - move=1: htrack+1, unless htrack == MAX_HTRACK.
  - move=3: htrack-1, unless htrack == 0.
  - move=2 (skipped phase): ignored.
- **Settle:**
  - Any accepted step, or a change of side_i when SIDES=2, reloads settle_cnt with SETTLE and sets pend.
  - settle_cnt decrements on ce.
  - When settle_cnt == 0 with pend set, the block publishes track_o <= htrack>>1 and side_o <= side latch, then clears pend.
- **Dirty tracking:**
  - we sets dirty.
  - A flush event with dirty=1 (or while a flush is still waiting) does the following:
    - If save_req=0: capture save_track <= track_o and save_side <= side_o, raise save_req, clear dirty.
    - If save_req=1: set flush_wait. The captured fields are not overwritten.
- **Flush events:**
  - an accepted step that changes htrack>>1, or a side change;
  - a falling edge of act;
  - idle_cnt reaching IDLE_FLUSH. idle_cnt reloads on we and decrements on ce while dirty.
- **Handshake:**
  - save_req stays high until save_ack=1 is sampled. It drops on the next clk.
  - If flush_wait is set, the next request is issued one clk after the drop, using the fields current at that time.
- **Image mount edge (highest priority):** clears dirty, flush_wait and save_req, abandoning any unacknowledged request.
- **Same-cycle events:**
  - we together with a step: the write belongs to the old track, is included in that flush, and dirty ends cleared.
  - we together with a request issue: dirty stays set.

## Timing
- **Values at reset:**
  - htrack = START_HTRACK; track_o = START_HTRACK>>1; side_o = 0.
  - save_req = 0; save_track = START_HTRACK>>1; save_side = 0.
  - dirty = pend = flush_wait = 0; counters = 0.
  - stp_prev = 0. The first stp sample after reset is absorbed with no step.
- **Latencies:**
  - stp change to htrack update: 1 clk.
  - Flush event to save_req high: 1 clk.
  - save_ack sampled to save_req low: 1 clk.
  - tr00_n is combinational from htrack.
- **Async reset** acts on all state. A reset during a pending request drops it with no ack required.

## Structure
- Put these in the shared iecdrv_pkg: the stepper-direction localparams (STEP_IN=1, STEP_OUT=3) and the default geometry constants (1541 and 1571 MAX_HTRACK / START_HTRACK).
- Split out one sub-module, iecdrv_stepper: phase-delta decode plus saturating half-track counter, outputting htrack and a step_accepted pulse.
- The settle logic, dirty/flush logic and handshake stay in the top.

## Test plan
- **Step in:** reset, mtr=1, stp 0→1→2→3→0 → htrack 36→40, track_o 20. With SETTLE=8, track_o updates only 8 ce after the last step.
- **Saturation and gating:**
  - At htrack=80, move=1 → htrack stays 80.
  - At 0, move=3 → stays 0 and tr00_n=0.
  - mtr=0 with stp toggling → no change.
- **Dirty on step:** we pulse on track 18, then step to track 19 → save_req=1 with save_track=18. Ack after 5 clks → req low 1 clk later.
- **Merged flushes:** a second we plus an act fall while req is pending → exactly one further request after ack, carrying the current track.
- **Idle flush:** IDLE_FLUSH=100, single we → save_req rises 100 ce later. A second we at tick 50 delays it to tick 150.
- **Mount mid-request:** img_mounted rises while save_req=1 → req low next clk, dirty=0, no further request. Also check a double-sided side toggle with dirty=1 → save_side captures the old side.

Source files
------------

// File: rtl/iecdrv_pkg.sv
// Shared constants for the IEC drive blocks: stepper phase deltas and drive geometry.
package iecdrv_pkg;
  localparam logic [1:0] STEP_IN  = 2'd1;
  localparam logic [1:0] STEP_OUT = 2'd3;

  localparam int MAX_HTRACK_1541   = 80;
  localparam int START_HTRACK_1541 = 36;
  localparam int MAX_HTRACK_1571   = 80;
  localparam int START_HTRACK_1571 = 36;
endpackage

// File: rtl/iecdrv_stepper.sv
// Stepper phase-delta decode and saturating half-track counter.
module iecdrv_stepper
  import iecdrv_pkg::*;
#(
  parameter int MAX_HTRACK   = MAX_HTRACK_1541,
  parameter int START_HTRACK = START_HTRACK_1541,
  parameter int HT_W         = $clog2(MAX_HTRACK + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      stp_i,
  input  logic            mtr_i,
  output logic [HT_W-1:0] htrack_o,
  output logic            step_o,
  output logic            trk_chg_o
);
  logic [1:0]      stp_prev_q, move;
  logic            primed_q;
  logic [HT_W-1:0] ht_q, ht_d;
  logic            step;

  // primed_q swallows the first phase sample after reset so a nonzero stp is not a step
  always_comb begin
    move = stp_i - stp_prev_q;
    ht_d = ht_q;
    step = 1'b0;
    if (primed_q && mtr_i) begin
      if (move == STEP_IN && ht_q != HT_W'(MAX_HTRACK)) begin
        ht_d = ht_q + HT_W'(1);
        step = 1'b1;
      end else if (move == STEP_OUT && ht_q != '0) begin
        ht_d = ht_q - HT_W'(1);
        step = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stp_prev_q <= 2'd0;
      primed_q   <= 1'b0;
      ht_q       <= HT_W'(START_HTRACK);
    end else begin
      stp_prev_q <= stp_i;
      primed_q   <= 1'b1;
      ht_q       <= ht_d;
    end
  end

  assign htrack_o  = ht_q;
  assign step_o    = step;
  assign trk_chg_o = step && (ht_d[HT_W-1:1] != ht_q[HT_W-1:1]);
endmodule

// File: rtl/iecdrv_head_ctrl.sv
// Head positioner with settle delay, side select, dirty tracking and save req/ack to the loader.
module iecdrv_head_ctrl
  import iecdrv_pkg::*;
#(
  parameter int MAX_HTRACK   = MAX_HTRACK_1541,
  parameter int START_HTRACK = START_HTRACK_1541,
  parameter int SIDES        = 1,
  parameter int SETTLE       = 0,
  parameter int IDLE_FLUSH   = 0,
  parameter int HT_W         = $clog2(MAX_HTRACK + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce,
  input  logic [1:0]      stp,
  input  logic            mtr,
  input  logic            act,
  input  logic            side_i,
  input  logic            we,
  input  logic            img_mounted,
  output logic [HT_W-1:0] htrack,
  output logic [HT_W-2:0] track_o,
  output logic            side_o,
  output logic            tr00_n,
  output logic            busy,
  output logic            save_req,
  output logic [HT_W-2:0] save_track,
  output logic            save_side,
  input  logic            save_ack
);
  localparam int SW = $clog2(SETTLE + 2);
  localparam int IW = $clog2(IDLE_FLUSH + 2);
  localparam logic [HT_W-2:0] START_TRK = (HT_W-1)'(START_HTRACK >> 1);

  logic            step_acc, trk_chg;
  logic [SW-1:0]   settle_q, settle_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [HT_W-2:0] track_q, track_d, stk_q, stk_d;
  logic            pend_q, pend_d, side_q, side_d, sideo_q, sideo_d, ssd_q, ssd_d;
  logic            dirty_q, dirty_d, fwait_q, fwait_d, req_q, req_d;
  logic            act_q, img_q;
  logic            side_new, side_chg, step_fl, idle_hit, flush_ev, fl_req;

  iecdrv_stepper #(
    .MAX_HTRACK(MAX_HTRACK), .START_HTRACK(START_HTRACK), .HT_W(HT_W)
  ) u_stepper (
    .clk_i(clk), .rst_i(reset), .stp_i(stp), .mtr_i(mtr),
    .htrack_o(htrack), .step_o(step_acc), .trk_chg_o(trk_chg)
  );

  assign side_new = (SIDES == 2) ? side_i : 1'b0;
  assign side_chg = side_new != side_q;
  assign step_fl  = step_acc && trk_chg;
  assign idle_hit = (IDLE_FLUSH != 0) && dirty_q && ce && (idle_q == IW'(1));
  assign flush_ev = step_fl || side_chg || (act_q && !act) || idle_hit;
  // a write landing with the track-changing step still belongs to the old track
  assign fl_req   = (flush_ev && (dirty_q || (we && step_fl))) || fwait_q;

  always_comb begin
    settle_d = settle_q;
    pend_d   = pend_q;
    track_d  = track_q;
    sideo_d  = sideo_q;
    side_d   = side_new;
    idle_d   = idle_q;
    dirty_d  = dirty_q;
    fwait_d  = fwait_q;
    req_d    = req_q;
    stk_d    = stk_q;
    ssd_d    = ssd_q;

    if (ce && settle_q != '0) settle_d = settle_q - SW'(1);
    if (pend_q && settle_q == '0) begin
      track_d = htrack[HT_W-1:1];
      sideo_d = side_q;
      pend_d  = 1'b0;
    end
    if (step_acc || side_chg) begin
      settle_d = SW'(SETTLE);
      pend_d   = 1'b1;
    end

    if (we) idle_d = IW'(IDLE_FLUSH);
    else if (dirty_q && ce && idle_q != '0) idle_d = idle_q - IW'(1);

    if (we) dirty_d = 1'b1;
    if (req_q && save_ack) req_d = 1'b0;
    if (fl_req) begin
      if (!req_q) begin
        req_d   = 1'b1;
        stk_d   = track_q;
        ssd_d   = sideo_q;
        fwait_d = 1'b0;
        dirty_d = we && !step_fl;
      end else begin
        fwait_d = 1'b1;
      end
    end

    if (img_mounted && !img_q) begin
      dirty_d = 1'b0;
      fwait_d = 1'b0;
      req_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_q <= '0;
      pend_q   <= 1'b0;
      track_q  <= START_TRK;
      sideo_q  <= 1'b0;
      side_q   <= 1'b0;
      idle_q   <= '0;
      dirty_q  <= 1'b0;
      fwait_q  <= 1'b0;
      req_q    <= 1'b0;
      stk_q    <= START_TRK;
      ssd_q    <= 1'b0;
      act_q    <= 1'b0;
      img_q    <= 1'b0;
    end else begin
      settle_q <= settle_d;
      pend_q   <= pend_d;
      track_q  <= track_d;
      sideo_q  <= sideo_d;
      side_q   <= side_d;
      idle_q   <= idle_d;
      dirty_q  <= dirty_d;
      fwait_q  <= fwait_d;
      req_q    <= req_d;
      stk_q    <= stk_d;
      ssd_q    <= ssd_d;
      act_q    <= act;
      img_q    <= img_mounted;
    end
  end

  assign track_o    = track_q;
  assign side_o     = sideo_q;
  assign tr00_n     = |htrack[HT_W-1:1];
  assign busy       = pend_q | req_q;
  assign save_req   = req_q;
  assign save_track = stk_q;
  assign save_side  = ssd_q;
endmodule
